// File: rtl/cfu_mac_engine_pkg.sv
// Shared opcodes, FSM state encoding and the int8x4 dot-product helper for the CFU MAC engine.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cfu_mac_engine_pkg;

  // funct3 groups
  localparam logic [2:0] F3_ALU = 3'd0;
  localparam logic [2:0] F3_MAC = 3'd1;
  localparam logic [2:0] F3_QNT = 3'd2;

  // ALU ops
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;

  // MAC ops
  localparam logic [3:0] MAC_ACC     = 4'd0;
  localparam logic [3:0] MAC_CLR     = 4'd1;
  localparam logic [3:0] MAC_SETOFF  = 4'd2;
  localparam logic [3:0] MAC_PUSH    = 4'd3;
  localparam logic [3:0] MAC_BUFMAC  = 4'd4;
  localparam logic [3:0] MAC_BUFMAC2 = 4'd5;
  localparam logic [3:0] MAC_REWIND  = 4'd6;
  localparam logic [3:0] MAC_BUFCLR  = 4'd7;
  localparam logic [3:0] MAC_GETACC  = 4'd8;

  // Requantizer ops
  localparam logic [3:0] QNT_BIAS  = 4'd0;
  localparam logic [3:0] QNT_MUL   = 4'd1;
  localparam logic [3:0] QNT_QOFF  = 4'd2;
  localparam logic [3:0] QNT_CLAMP = 4'd3;
  localparam logic [3:0] QNT_RUN   = 4'd4;

  // Command FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_QBUSY = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int QNT_STAGES = 3;

  // Sum over the four signed byte lanes of (a + off) * w, wrapping at 32 bits.
  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] w,
                                       input logic [31:0] off);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + (32'($signed(a[8*i +: 8])) + off) * 32'($signed(w[8*i +: 8]));
    end
    return s;
  endfunction

endpackage

// File: rtl/cfu_mac_engine_qnt_pipe.sv
// Three-stage requantizer: bias add, rounding doubling-high multiply, rounding shift + offset + clamp.
// Latency: vld_o rises QNT_STAGES cycles after vld_i is sampled.
// Backpressure: none; the caller keeps the config inputs stable while a token is in flight.
module cfu_mac_engine_qnt_pipe
  import cfu_mac_engine_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        vld_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] bias_i,
  input  logic [31:0] mul_i,
  input  logic [4:0]  shift_i,
  input  logic [31:0] qoff_i,
  input  logic [31:0] min_i,
  input  logic [31:0] max_i,
  output logic        vld_o,
  output logic [31:0] dat_o
);

  logic [QNT_STAGES-1:0] vld_q;
  logic [31:0]           x_q, h_q, out_q;
  logic [31:0]           x_d, h_d, out_d, r, v;
  logic signed [63:0]    prod, hw;
  logic signed [32:0]    hx, rnd, r33;
  logic                  unused_bits;

  // Stage arithmetic; the rounding shift runs at 33 bits so h + rounding cannot overflow.
  always_comb begin
    x_d   = acc_i + bias_i;
    prod  = 64'($signed(x_q)) * 64'($signed(mul_i));
    hw    = (prod + (64'sd1 <<< 30)) >>> 31;
    h_d   = (x_q == 32'h8000_0000 && mul_i == 32'h8000_0000) ? 32'h7FFF_FFFF : hw[31:0];
    hx    = {h_q[31], h_q};
    rnd   = (shift_i == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift_i - 5'd1));
    r33   = (hx + rnd) >>> shift_i;
    r     = r33[31:0];
    v     = r + qoff_i;
    out_d = ($signed(v) < $signed(min_i)) ? min_i :
            ($signed(v) > $signed(max_i)) ? max_i : v;
  end

  assign unused_bits = ^{hw[63:32], r33[32]};

  // Valid token shifts along; each data stage loads only when its input token is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      x_q   <= '0;
      h_q   <= '0;
      out_q <= '0;
    end else begin
      vld_q <= {vld_q[QNT_STAGES-2:0], vld_i};
      if (vld_i)    x_q   <= x_d;
      if (vld_q[0]) h_q   <= h_d;
      if (vld_q[1]) out_q <= out_d;
    end
  end

  assign vld_o = vld_q[QNT_STAGES-1];
  assign dat_o = out_q;

endmodule

// File: rtl/cfu_mac_engine.sv
// CFU accelerator top: ALU ops, int8x4 SIMD MAC into NUM_ACC accumulators, activation buffer, requantizer.
// Latency: response one cycle after accept, four cycles for a requantize run.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module cfu_mac_engine
  import cfu_mac_engine_pkg::*;
#(
  parameter int NUM_ACC   = 4,
  parameter int BUF_DEPTH = 256,
  parameter int BUF_AW    = $clog2(BUF_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int              ACC_AW   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam logic [BUF_AW:0] CNT_ONE  = (BUF_AW+1)'(1);
  localparam logic [BUF_AW:0] CNT_FULL = (BUF_AW+1)'(BUF_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [31:0]       acc_q [NUM_ACC];
  logic [31:0]       offset_q, bias_q, mul_q, qoff_q, min_q, max_q, rsp_q;
  logic [4:0]        shift_q;
  logic [31:0]       mem [BUF_DEPTH];
  logic [BUF_AW:0]   count_q, count_d, ptr1_inc, ptr2_inc;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d, ptr1, ptr2;

  logic [2:0]        f3, sel;
  logic [3:0]        op;
  logic              sel_ok, accept;
  logic [ACC_AW-1:0] sel_idx;
  logic [31:0]       in_a, in_b, acc_sel, word0, word1, acc_wdat, res_d, q_dat;
  logic              acc_we, off_we, push_we, bias_we, mul_we, qoff_we, clamp_we, qnt_go, q_vld;

  assign f3      = cmd_payload_function_id[2:0];
  assign op      = cmd_payload_function_id[6:3];
  assign sel     = cmd_payload_function_id[9:7];
  assign in_a    = cmd_payload_inputs_0;
  assign in_b    = cmd_payload_inputs_1;
  assign sel_ok  = ({1'b0, sel} < 4'(NUM_ACC));
  assign sel_idx = sel[ACC_AW-1:0];
  assign acc_sel = acc_q[sel_idx];
  assign accept  = cmd_valid && cmd_ready;

  // Read pointer and its next two wrapped successors; with count==1 both wrap back to word 0.
  assign ptr1_inc = {1'b0, rd_ptr_q} + CNT_ONE;
  assign ptr1     = (ptr1_inc == count_q) ? '0 : ptr1_inc[BUF_AW-1:0];
  assign ptr2_inc = {1'b0, ptr1} + CNT_ONE;
  assign ptr2     = (ptr2_inc == count_q) ? '0 : ptr2_inc[BUF_AW-1:0];
  assign word0    = mem[rd_ptr_q];
  assign word1    = mem[ptr1];

  // Command decode: immediate result plus the state updates that commit on accept.
  always_comb begin
    res_d    = '0;
    acc_we   = 1'b0;
    acc_wdat = acc_sel;
    off_we   = 1'b0;
    push_we  = 1'b0;
    bias_we  = 1'b0;
    mul_we   = 1'b0;
    qoff_we  = 1'b0;
    clamp_we = 1'b0;
    qnt_go   = 1'b0;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    case (f3)
      F3_ALU: begin
        case (op)
          ALU_ADD: res_d = in_a + in_b;
          ALU_SUB: res_d = in_a - in_b;
          ALU_MUL: res_d = in_a * in_b;
          default: res_d = '0;
        endcase
      end
      F3_MAC: begin
        case (op)
          MAC_ACC: if (sel_ok) begin
            acc_we   = 1'b1;
            acc_wdat = acc_sel + dot4(in_a, in_b, offset_q);
            res_d    = acc_wdat;
          end
          MAC_CLR: if (sel_ok) begin
            acc_we   = 1'b1;
            acc_wdat = '0;
          end
          MAC_SETOFF: off_we = 1'b1;
          MAC_PUSH: begin
            if (count_q != CNT_FULL) begin
              push_we = 1'b1;
              count_d = count_q + CNT_ONE;
            end else begin
              res_d = '1;
            end
          end
          MAC_BUFMAC, MAC_BUFMAC2: if (sel_ok) begin
            if (count_q == '0) begin
              res_d = acc_sel;
            end else begin
              acc_we = 1'b1;
              if (op == MAC_BUFMAC) begin
                acc_wdat = acc_sel + dot4(word0, in_a, offset_q);
                rd_ptr_d = ptr1;
              end else begin
                acc_wdat = acc_sel + dot4(word0, in_a, offset_q) + dot4(word1, in_b, offset_q);
                rd_ptr_d = ptr2;
              end
              res_d = acc_wdat;
            end
          end
          MAC_REWIND: begin
            rd_ptr_d = '0;
            res_d    = 32'(count_q);
          end
          MAC_BUFCLR: begin
            count_d  = '0;
            rd_ptr_d = '0;
          end
          MAC_GETACC: if (sel_ok) res_d = acc_sel;
          default: res_d = '0;
        endcase
      end
      F3_QNT: begin
        case (op)
          QNT_BIAS:  bias_we  = 1'b1;
          QNT_MUL:   mul_we   = 1'b1;
          QNT_QOFF:  qoff_we  = 1'b1;
          QNT_CLAMP: clamp_we = 1'b1;
          QNT_RUN:   qnt_go   = sel_ok;
          default:   res_d    = '0;
        endcase
      end
      default: res_d = '0;
    endcase
  end

  // Handshake FSM: IDLE accepts, QBUSY waits on the requantizer, RESP holds until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = qnt_go ? ST_QBUSY : ST_RESP;
      ST_QBUSY: if (q_vld) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Architectural state: FSM, response, accumulators, offset, requantizer config, buffer bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rsp_q    <= '0;
      offset_q <= '0;
      bias_q   <= '0;
      mul_q    <= '0;
      shift_q  <= '0;
      qoff_q   <= '0;
      min_q    <= '0;
      max_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !qnt_go) rsp_q <= res_d;
      else if (state_q == ST_QBUSY && q_vld) rsp_q <= q_dat;
      if (accept) begin
        if (acc_we)   acc_q[sel_idx] <= acc_wdat;
        if (off_we)   offset_q <= in_a;
        if (bias_we)  bias_q <= in_a;
        if (mul_we) begin
          mul_q   <= in_a;
          shift_q <= in_b[4:0];
        end
        if (qoff_we)  qoff_q <= in_a;
        if (clamp_we) begin
          min_q <= in_a;
          max_q <= in_b;
        end
        count_q  <= count_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end
  end

  // Activation buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && push_we) mem[count_q[BUF_AW-1:0]] <= in_a;
  end

  cfu_mac_engine_qnt_pipe u_qnt (
    .clk     (clk),
    .reset   (reset),
    .vld_i   (accept && qnt_go),
    .acc_i   (acc_sel),
    .bias_i  (bias_q),
    .mul_i   (mul_q),
    .shift_i (shift_q),
    .qoff_i  (qoff_q),
    .min_i   (min_q),
    .max_i   (max_q),
    .vld_o   (q_vld),
    .dat_o   (q_dat)
  );

  assign cmd_ready             = (state_q == ST_IDLE);
  assign rsp_valid             = (state_q == ST_RESP);
  assign rsp_payload_outputs_0 = rsp_q;

endmodule

// File: tb/tb_cfu_mac_engine.sv
// Directed + randomized bench for cfu_mac_engine against an arithmetic reference model.
// Latency: checks one-cycle and four-cycle response timing.
// Backpressure: holds rsp_ready low and drives cmd_valid while a response is pending.
module tb_cfu_mac_engine;
  localparam int NUM_ACC = 4;
  localparam int DEPTH   = 256;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0, in1 = '0, rsp_dat;
  int          checks = 0, failures = 0;

  cfu_mac_engine #(.NUM_ACC(NUM_ACC), .BUF_DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_acc [NUM_ACC];
  int m_mem [DEPTH];
  int m_off, m_cnt, m_ptr, m_bias, m_mul, m_shift, m_qoff, m_min, m_max, m_lat;

  function automatic void m_reset();
    foreach (m_acc[i]) m_acc[i] = 0;
    m_off = 0; m_cnt = 0; m_ptr = 0;
    m_bias = 0; m_mul = 0; m_shift = 0; m_qoff = 0; m_min = 0; m_max = 0;
  endfunction

  function automatic int lane(int v, int i);
    byte b;
    b = v[8*i +: 8];
    return int'(b);
  endfunction

  function automatic int mdot(int a, int w);
    int s = 0;
    for (int i = 0; i < 4; i++) s += (lane(a, i) + m_off) * lane(w, i);
    return s;
  endfunction

  function automatic int mqnt(int acc);
    int x, h, r, v;
    longint p;
    x = acc + m_bias;
    p = longint'(x) * longint'(m_mul);
    if (x == 32'h8000_0000 && m_mul == 32'h8000_0000) h = 32'h7FFF_FFFF;
    else h = int'((p + (longint'(1) << 30)) >>> 31);
    if (m_shift == 0) r = h;
    else r = int'((longint'(h) + (longint'(1) << (m_shift - 1))) >>> m_shift);
    v = r + m_qoff;
    if (v < m_min) return m_min;
    if (v > m_max) return m_max;
    return v;
  endfunction

  // Applies one command to the model; returns expected response, sets expected latency.
  function automatic int m_exec(int f3, int op, int sel, int a, int b);
    bit sv = (sel < NUM_ACC);
    m_lat = 1;
    if (f3 == 0) begin
      if (op == 0) return a + b;
      if (op == 1) return a - b;
      if (op == 2) return a * b;
      return 0;
    end
    if (f3 == 1) begin
      case (op)
        0: if (sv) begin m_acc[sel] += mdot(a, b); return m_acc[sel]; end
        1: if (sv) m_acc[sel] = 0;
        2: m_off = a;
        3: begin
          if (m_cnt >= DEPTH) return -1;
          m_mem[m_cnt] = a; m_cnt++;
        end
        4, 5: if (sv) begin
          if (m_cnt == 0) return m_acc[sel];
          if (op == 4) begin
            m_acc[sel] += mdot(m_mem[m_ptr], a);
            m_ptr = (m_ptr + 1) % m_cnt;
          end else begin
            m_acc[sel] += mdot(m_mem[m_ptr], a) + mdot(m_mem[(m_ptr + 1) % m_cnt], b);
            m_ptr = (m_ptr + 2) % m_cnt;
          end
          return m_acc[sel];
        end
        6: begin m_ptr = 0; return m_cnt; end
        7: begin m_cnt = 0; m_ptr = 0; end
        8: if (sv) return m_acc[sel];
        default: ;
      endcase
      return 0;
    end
    if (f3 == 2) begin
      case (op)
        0: m_bias = a;
        1: begin m_mul = a; m_shift = b & 31; end
        2: m_qoff = a;
        3: begin m_min = a; m_max = b; end
        4: if (sv) begin m_lat = 4; return mqnt(m_acc[sel]); end
        default: ;
      endcase
    end
    return 0;
  endfunction

  // ---------------- checking and driving ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns after the response handshake.
  task automatic issue(input int f3, input int op, input int sel, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output int lat);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    fid = {3'(sel), 4'(op), 3'(f3)}; in0 = a; in1 = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
    r = rsp_dat;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ready_after_hs", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run(input string tag, input int f3, input int op, input int sel,
                     input logic [31:0] a, input logic [31:0] b, output logic [31:0] got);
    int exp, elat, lat;
    exp  = m_exec(f3, op, sel, a, b);
    elat = m_lat;
    issue(f3, op, sel, a, b, got, lat);
    chk(tag, got, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    logic [31:0] got, held, acc_before;
    int expb;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_outputs", rsp_dat, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset pulse while a requantize is in flight aborts it silently
    fid = {3'd0, 4'd4, 3'd2}; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("qbusy_no_rsp", 32'(rsp_valid), 32'd0);
    chk("qbusy_not_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk("postrst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run("getacc0_after_rst", 1, 8, 0, 0, 0, got);
    chk("getacc0_zero", got, 32'd0);

    // Offset applied to activations
    run("setoff128", 1, 2, 0, 128, 0, got);
    run("acc1", 1, 0, 1, 32'h0102_0304, 32'h0101_0101, got);
    chk("acc1_522", got, 32'd522);
    run("getacc1", 1, 8, 1, 0, 0, got);
    chk("getacc1_522", got, 32'd522);
    run("getacc0", 1, 8, 0, 0, 0, got);
    chk("getacc0_still0", got, 32'd0);

    // Buffer recirculation
    run("setoff0", 1, 2, 0, 0, 0, got);
    run("push_a", 1, 3, 0, 32'h0101_0101, 0, got);
    run("push_b", 1, 3, 0, 32'h0202_0202, 0, got);
    run("bufmac_1", 1, 4, 2, 32'h0101_0101, 0, got);
    chk("bufmac_4", got, 32'd4);
    run("bufmac_2", 1, 4, 2, 32'h0101_0101, 0, got);
    chk("bufmac_12", got, 32'd12);
    run("bufmac_3", 1, 4, 2, 32'h0101_0101, 0, got);
    chk("bufmac_16_wrap", got, 32'd16);
    run("rewind", 1, 6, 0, 0, 0, got);
    chk("rewind_2", got, 32'd2);
    run("bufmac2_cnt2", 1, 5, 2, $urandom, $urandom, got);

    // Fill to capacity, overflow push, then clear
    run("bufclr", 1, 7, 0, 0, 0, got);
    for (int i = 0; i < DEPTH; i++) run("push_fill", 1, 3, 0, $urandom, 0, got);
    run("push_full", 1, 3, 0, 32'h1234_5678, 0, got);
    chk("push_full_ff", got, 32'hFFFF_FFFF);
    run("rewind_full", 1, 6, 0, 0, 0, got);
    chk("rewind_full_cnt", got, 32'(DEPTH));
    for (int i = 0; i < 6; i++) run("bufmac2_full", 1, 5, i % NUM_ACC, $urandom, $urandom, got);
    run("bufmac_full", 1, 4, 1, $urandom, 0, got);
    run("getacc2_pre", 1, 8, 2, 0, 0, acc_before);
    run("bufclr2", 1, 7, 0, 0, 0, got);
    run("bufmac_empty", 1, 4, 2, $urandom, 0, got);
    chk("bufmac_empty_same", got, acc_before);
    run("push_one", 1, 3, 0, $urandom, 0, got);
    run("bufmac2_cnt1", 1, 5, 0, $urandom, $urandom, got);
    run("bufmac2_cnt1b", 1, 5, 0, $urandom, $urandom, got);

    // Requantizer: acc=100 -> -103; acc=1000 stays inside the window (122); acc=2000 saturates at MAX
    run("setoff0b", 1, 2, 0, 0, 0, got);
    run("clr3", 1, 1, 3, 0, 0, got);
    run("acc3_100", 1, 0, 3, 32'h64, 32'h1, got);
    run("q_bias", 2, 0, 0, 0, 0, got);
    run("q_mul", 2, 1, 0, 32'h4000_0000, 1, got);
    run("q_qoff", 2, 2, 0, -128, 0, got);
    run("q_clamp", 2, 3, 0, -128, 127, got);
    run("q_run100", 2, 4, 3, 0, 0, got);
    chk("q_run100_val", got, 32'hFFFF_FF99);
    run("clr3b", 1, 1, 3, 0, 0, got);
    run("acc3_800", 1, 0, 3, 32'h6464_6464, 32'h0202_0202, got);
    run("acc3_1000", 1, 0, 3, 32'h64, 32'h2, got);
    run("q_run1000", 2, 4, 3, 0, 0, got);
    chk("q_run1000_val", got, 32'd122);
    run("acc3_1800", 1, 0, 3, 32'h6464_6464, 32'h0202_0202, got);
    run("acc3_2000", 1, 0, 3, 32'h64, 32'h2, got);
    run("q_run2000", 2, 4, 3, 0, 0, got);
    chk("q_run2000_clamp", got, 32'd127);
    run("getacc3_kept", 1, 8, 3, 0, 0, got);
    chk("getacc3_2000", got, 32'd2000);

    // Response backpressure with a competing command held on the bus
    fid = {3'd1, 4'd8, 3'd1}; cmd_valid = 1'b1;
    held = m_exec(1, 8, 1, 0, 0);
    @(posedge clk); #1;
    fid = {3'd0, 4'd0, 3'd1}; in0 = $urandom; in1 = $urandom;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_payload", rsp_dat, held);
      chk("hold_not_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("b2b_ready_m1", 32'(cmd_ready), 32'd1);
    expb = m_exec(1, 0, 0, in0, in1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_payload", rsp_dat, 32'(expb));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    run("b2b_once", 1, 8, 0, 0, 0, got);

    // Random mix of every command class, including invalid selects/ops/funct3
    for (int i = 0; i < 120; i++) begin
      int f3, op, sel;
      f3  = $urandom_range(0, 3);
      op  = $urandom_range(0, (i % 8 == 0) ? 15 : 8);
      sel = $urandom_range(0, NUM_ACC);
      if (f3 == 2 && op == 3) run("rnd", f3, op, sel, -(1 << 20), 1 << 20, got);
      else run("rnd", f3, op, sel, $urandom, $urandom, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
